// File: rtl/enc_quad_decoder.sv
// Differential quadrature encoder receiver: sync, glitch filter, 4x decode, position and line trigger.
// Define ENC_INDEX_CLR_EN to make the filtered Z rising edge zero POS.
module enc_quad_decoder #(
   parameter int FILT_LEN = 4,
   parameter int CNT_W    = 32,
   parameter int DIV_W    = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [2:0]       ENC_P,
   input  logic [2:0]       ENC_N,
   input  logic [DIV_W-1:0] DIV,
   input  logic             DIR_INV,
   input  logic             CLR,
   input  logic             ERR_CLR,
   output logic [CNT_W-1:0] POS,
   output logic             DIR,
   output logic             STEP,
   output logic             LINE_TRIG,
   output logic             INDEX,
   output logic             ERR_SEQ,
   output logic             ERR_DIFF
);
   localparam int NF   = 6;
   localparam int FW   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam int WARM = FILT_LEN + 3;
   localparam int WW   = $clog2(WARM + 1);
   localparam int AW   = DIV_W + 1;
   localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {DIV_W{1'b0}}} + AW'(1);

   logic [2:0]            p_s1_q, p_s1_d, p_s2_q, p_s2_d;
   logic [2:0]            n_s1_q, n_s1_d, n_s2_q, n_s2_d;
   logic [NF-1:0]         smp, filt_q, filt_d;
   logic [NF-1:0][FW-1:0] fcnt_q, fcnt_d;
   logic [WW-1:0]         warm_q, warm_d;
   logic [1:0]            ab_prev_q, ab_prev_d;
   logic                  z_prev_q, z_prev_d;
   logic signed [AW-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]      pos_q, pos_d;
   logic                  dir_q, dir_d, step_q, step_d, trig_q, trig_d, idx_q, idx_d;
   logic                  err_seq_q, err_seq_d, err_diff_q, err_diff_d;
   logic                  armed, cnt_ev, both, fwd;
   logic [AW-1:0]         div_m1;

   // filter bits [2:0] = P lines A/B/Z, [5:3] = per-channel P==N fault
   assign smp    = {p_s2_q ~^ n_s2_q, p_s2_q};
   assign armed  = (warm_q == WW'(WARM));
   assign div_m1 = (DIV == '0) ? '0 : {1'b0, DIV - 1'b1};

   always_comb begin
      p_s1_d = ENC_P;
      n_s1_d = ENC_N;
      p_s2_d = p_s1_q;
      n_s2_d = n_s1_q;
      for (int i = 0; i < NF; i++) begin
         filt_d[i] = filt_q[i];
         fcnt_d[i] = '0;
         if (smp[i] != filt_q[i]) begin
            if (fcnt_q[i] == FW'(FILT_LEN - 1)) filt_d[i] = smp[i];
            else                                fcnt_d[i] = fcnt_q[i] + 1'b1;
         end
      end
   end

   // Until the filters have settled after reset, prev just tracks the filtered inputs.
   always_comb begin
      warm_d     = armed ? warm_q : warm_q + 1'b1;
      ab_prev_d  = filt_q[1:0];
      z_prev_d   = filt_q[2];
      both       = &(filt_q[1:0] ^ ab_prev_q);
      cnt_ev     = armed && ((filt_q[0] ^ ab_prev_q[0]) != (filt_q[1] ^ ab_prev_q[1]));
      fwd        = ~(ab_prev_q[0] ^ filt_q[1]) ^ DIR_INV;
      step_d     = cnt_ev;
      idx_d      = armed & filt_q[2] & ~z_prev_q;
      dir_d      = cnt_ev ? fwd : dir_q;
      trig_d     = 1'b0;
      pos_d      = pos_q;
      acc_d      = acc_q;
      if (cnt_ev) begin
         pos_d = fwd ? pos_q + 1'b1 : pos_q - 1'b1;
         if (fwd) begin
            if (acc_q >= $signed(div_m1)) begin
               trig_d = 1'b1;
               acc_d  = '0;
            end else begin
               acc_d = acc_q + AW'(1);
            end
         end else if (acc_q != ACC_MIN) begin
            acc_d = acc_q - AW'(1);
         end
      end
`ifdef ENC_INDEX_CLR_EN
      if (idx_d) pos_d = '0;
`else
`endif
      if (CLR) begin
         pos_d  = '0;
         acc_d  = '0;
         trig_d = 1'b0;
      end
      err_seq_d  = (ERR_CLR ? 1'b0 : err_seq_q)  | (armed & both);
      err_diff_d = (ERR_CLR ? 1'b0 : err_diff_q) | (armed & (|filt_q[5:3]));
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         p_s1_q     <= '0;
         n_s1_q     <= '0;
         p_s2_q     <= '0;
         n_s2_q     <= '0;
         filt_q     <= '0;
         fcnt_q     <= '0;
         warm_q     <= '0;
         ab_prev_q  <= '0;
         z_prev_q   <= 1'b0;
         acc_q      <= '0;
         pos_q      <= '0;
         dir_q      <= 1'b0;
         step_q     <= 1'b0;
         trig_q     <= 1'b0;
         idx_q      <= 1'b0;
         err_seq_q  <= 1'b0;
         err_diff_q <= 1'b0;
      end else begin
         p_s1_q     <= p_s1_d;
         n_s1_q     <= n_s1_d;
         p_s2_q     <= p_s2_d;
         n_s2_q     <= n_s2_d;
         filt_q     <= filt_d;
         fcnt_q     <= fcnt_d;
         warm_q     <= warm_d;
         ab_prev_q  <= ab_prev_d;
         z_prev_q   <= z_prev_d;
         acc_q      <= acc_d;
         pos_q      <= pos_d;
         dir_q      <= dir_d;
         step_q     <= step_d;
         trig_q     <= trig_d;
         idx_q      <= idx_d;
         err_seq_q  <= err_seq_d;
         err_diff_q <= err_diff_d;
      end
   end

   assign POS       = pos_q;
   assign DIR       = dir_q;
   assign STEP      = step_q;
   assign LINE_TRIG = trig_q;
   assign INDEX     = idx_q;
   assign ERR_SEQ   = err_seq_q;
   assign ERR_DIFF  = err_diff_q;
endmodule

// File: tb/tb_enc_quad_decoder.sv
// Self-checking bench for enc_quad_decoder: motion table, randomized moves vs. count-level model, corner sequences.
module tb_enc_quad_decoder;
   localparam int DW      = 4;
   localparam int ACC_MIN = -(2**DW - 1);

   logic          CLK, RST_N, DIR_INV, CLR, ERR_CLR;
   logic [2:0]    ENC_P, ENC_N;
   logic [DW-1:0] DIV;
   logic [31:0]   POS;
   logic          DIR, STEP, LINE_TRIG, INDEX, ERR_SEQ, ERR_DIFF;

   enc_quad_decoder #(.FILT_LEN(4), .CNT_W(32), .DIV_W(DW)) dut (
      .CLK(CLK), .RST_N(RST_N), .ENC_P(ENC_P), .ENC_N(ENC_N), .DIV(DIV),
      .DIR_INV(DIR_INV), .CLR(CLR), .ERR_CLR(ERR_CLR), .POS(POS), .DIR(DIR),
      .STEP(STEP), .LINE_TRIG(LINE_TRIG), .INDEX(INDEX), .ERR_SEQ(ERR_SEQ),
      .ERR_DIFF(ERR_DIFF));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0, errors = 0;
   int step_cnt = 0, trig_cnt = 0, idx_cnt = 0, eseq_cyc = 0;
   bit trig_q[$];
   bit exp_tq[$];

   // count-level model
   logic [1:0]  gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
   int          phase = 0;
   logic        z_v = 1'b0;
   logic [31:0] m_pos = '0;
   int          m_acc = 0, m_steps = 0;
   bit          m_dir = 1'b0;

   always @(negedge CLK) begin
      if (RST_N) begin
         if (STEP) begin
            step_cnt++;
            trig_q.push_back(LINE_TRIG);
         end
         if (LINE_TRIG) trig_cnt++;
         if (INDEX) idx_cnt++;
         if (ERR_SEQ) eseq_cyc++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive();
      ENC_P = {z_v, gray[phase]};
      ENC_N = ~{z_v, gray[phase]};
   endtask

   task automatic model_count(input bit lf);
      int de;
      de = (int'(DIV) == 0) ? 1 : int'(DIV);
      m_steps++;
      m_dir = lf;
      if (lf) begin
         m_pos = m_pos + 1;
         if (m_acc >= de - 1) begin
            m_acc = 0;
            exp_tq.push_back(1'b1);
         end else begin
            m_acc++;
            exp_tq.push_back(1'b0);
         end
      end else begin
         m_pos = m_pos - 1;
         if (m_acc > ACC_MIN) m_acc--;
         exp_tq.push_back(1'b0);
      end
   endtask

   task automatic move(input bit pf, input int hold);
      phase = pf ? (phase + 1) % 4 : (phase + 3) % 4;
      drive();
      model_count(pf ^ DIR_INV);
      tick(hold);
   endtask

   task automatic clear_all();
      CLR = 1'b1;
      tick(1);
      CLR = 1'b0;
      step_cnt = 0;
      trig_cnt = 0;
      idx_cnt  = 0;
      trig_q.delete();
      exp_tq.delete();
      m_pos   = '0;
      m_acc   = 0;
      m_steps = 0;
   endtask

   task automatic check_trigs(input string nm);
      int mis = 0;
      check({nm, " ntrig"}, trig_q.size(), exp_tq.size());
      if (trig_q.size() == exp_tq.size())
         foreach (trig_q[i]) if (trig_q[i] != exp_tq[i]) mis++;
      check({nm, " trigseq"}, mis, 0);
   endtask

   typedef struct {
      bit inv; int div; int f1; int b; int f2;
      int exp_pos; bit exp_dir; int exp_steps; int exp_trigs;
   } row_t;

   row_t rows [8];

   initial begin
      int n;
      logic [31:0] pos0;
      rows[0] = '{0, 10, 40, 0,  0,  40, 1, 40, 4};
      rows[1] = '{1, 10, 40, 0,  0, -40, 0, 40, 0};
      rows[2] = '{0,  4,  6, 3,  4,   7, 1, 13, 1};
      rows[3] = '{0,  4,  6, 3,  5,   8, 1, 14, 2};
      rows[4] = '{0,  0,  3, 0,  0,   3, 1,  3, 3};
      rows[5] = '{1,  2,  0, 4,  0,   4, 1,  4, 2};
      rows[6] = '{0,  2,  0, 20, 17, -3, 1, 37, 1};
      rows[7] = '{0,  3,  2, 5,  0,  -3, 0,  7, 0};

      RST_N = 1'b0; CLR = 1'b0; ERR_CLR = 1'b0; DIR_INV = 1'b0; DIV = DW'(1);
      drive();
      tick(3);
      check("rst POS", POS, 0);
      check("rst DIR", DIR, 0);
      check("rst STEP", STEP, 0);
      check("rst LINE_TRIG", LINE_TRIG, 0);
      check("rst INDEX", INDEX, 0);
      check("rst ERR_SEQ", ERR_SEQ, 0);
      check("rst ERR_DIFF", ERR_DIFF, 0);
      RST_N = 1'b1;
      tick(20);

      // motion table
      for (int k = 0; k < 8; k++) begin
         DIR_INV = rows[k].inv;
         DIV     = DW'(rows[k].div);
         clear_all();
         for (int j = 0; j < rows[k].f1; j++) move(1'b1, 10);
         for (int j = 0; j < rows[k].b;  j++) move(1'b0, 10);
         for (int j = 0; j < rows[k].f2; j++) move(1'b1, 10);
         check($sformatf("row%0d POS", k), POS, rows[k].exp_pos);
         check($sformatf("row%0d DIR", k), DIR, rows[k].exp_dir);
         check($sformatf("row%0d steps", k), step_cnt, rows[k].exp_steps);
         check($sformatf("row%0d trigs", k), trig_cnt, rows[k].exp_trigs);
         check($sformatf("row%0d model POS", k), POS, m_pos);
         check_trigs($sformatf("row%0d", k));
         check($sformatf("row%0d ERR_SEQ", k), ERR_SEQ, 0);
      end

      // randomized motion against the model
      DIR_INV = 1'b0;
      DIV = DW'(5);
      clear_all();
      for (int i = 0; i < 80; i++) begin
         if (i % 10 == 0) DIV = DW'($urandom_range(0, 7));
         if (i % 16 == 0) DIR_INV = 1'($urandom_range(0, 1));
         move(1'($urandom_range(0, 1)), $urandom_range(8, 16));
         check($sformatf("rand%0d POS", i), POS, m_pos);
      end
      check("rand DIR", DIR, m_dir);
      check("rand steps", step_cnt, m_steps);
      check_trigs("rand");
      DIR_INV = 1'b0;

      // edge-to-STEP latency, trigger in the same cycle
      DIV = DW'(1);
      clear_all();
      phase = (phase + 1) % 4;
      drive();
      n = 0;
      while (n < 20) begin
         tick(1);
         n++;
         if (STEP) break;
      end
      check("latency", n, 7);
      check("trig with step", LINE_TRIG, 1);
      tick(1);
      check("step one cycle", STEP, 0);
      tick(10);

      // 2-cycle glitch on A is rejected
      pos0 = POS;
      step_cnt = 0;
      ENC_P[0] = ~ENC_P[0]; ENC_N[0] = ~ENC_N[0];
      tick(2);
      drive();
      tick(12);
      check("glitch steps", step_cnt, 0);
      check("glitch POS", POS, pos0);

      // A and B flipped together
      phase = (phase + 2) % 4;
      drive();
      tick(12);
      check("dbl ERR_SEQ", ERR_SEQ, 1);
      check("dbl POS", POS, pos0);
      check("dbl steps", step_cnt, 0);
      ERR_CLR = 1'b1; tick(1); ERR_CLR = 1'b0; tick(1);
      check("ERR_CLR seq", ERR_SEQ, 0);
      eseq_cyc = 0;
      ERR_CLR = 1'b1;
      phase = (phase + 2) % 4;
      drive();
      tick(12);
      ERR_CLR = 1'b0;
      tick(1);
      check("set wins cycles", eseq_cyc, 1);
      check("set wins after", ERR_SEQ, 0);
      move(1'b1, 10);
      check("count after dbl", POS, pos0 + 32'd1);

      // differential fault on B
      step_cnt = 0;
      ENC_N[1] = ENC_P[1];
      tick(4);
      check("diff early", ERR_DIFF, 0);
      tick(4);
      check("diff set", ERR_DIFF, 1);
      tick(2);
      drive();
      tick(20);
      check("diff sticky", ERR_DIFF, 1);
      check("diff steps", step_cnt, 0);
      ERR_CLR = 1'b1; tick(1); ERR_CLR = 1'b0; tick(1);
      check("ERR_CLR diff", ERR_DIFF, 0);

      // index pulse at POS=123
      DIV = DW'(10);
      clear_all();
      for (int j = 0; j < 123; j++) move(1'b1, 10);
      check("pre-index POS", POS, 123);
      z_v = 1'b1;
      drive();
      tick(12);
      check("index pulses", idx_cnt, 1);
`ifdef ENC_INDEX_CLR_EN
      check("index POS", POS, 0);
`else
      check("index POS", POS, 123);
`endif
      z_v = 1'b0;
      drive();
      tick(12);
      check("index fall", idx_cnt, 1);

      // CLR together with a count that would have triggered
      DIV = DW'(3);
      clear_all();
      move(1'b1, 10);
      move(1'b1, 10);
      phase = (phase + 1) % 4;
      drive();
      tick(6);
      CLR = 1'b1;
      tick(1);
      CLR = 1'b0;
      check("clr STEP", STEP, 1);
      check("clr LINE_TRIG", LINE_TRIG, 0);
      check("clr POS", POS, 0);
      tick(5);
      trig_cnt = 0;
      move(1'b1, 10);
      move(1'b1, 10);
      check("clr acc no trig", trig_cnt, 0);
      move(1'b1, 10);
      check("clr acc trig", trig_cnt, 1);
      check("clr acc POS", POS, 3);

      // asynchronous reset mid-motion, restart from a non-zero phase
      while (phase != 1) move(1'b1, 10);
      phase = 2;
      drive();
      tick(3);
      RST_N = 1'b0;
      tick(2);
      check("mid rst POS", POS, 0);
      check("mid rst STEP", STEP, 0);
      check("mid rst DIR", DIR, 0);
      step_cnt = 0;
      RST_N = 1'b1;
      tick(20);
      check("restart steps", step_cnt, 0);
      check("restart POS", POS, 0);
      check("restart ERR_SEQ", ERR_SEQ, 0);
      check("restart ERR_DIFF", ERR_DIFF, 0);
      move(1'b1, 10);
      check("restart count", POS, 1);
      check("restart DIR", DIR, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
